// File: rtl/cpc_mem_scheduler.sv
// Time-slot arbiter sharing one external memory port between video, CPU and host.
// Each access holds mem_cs_o for ACCESS_CYCLES cycles, then pulses the winner's ack.
module cpc_mem_scheduler #(
  parameter int unsigned AW            = 20,
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_addr_i,
  output logic          vid_ack_o,
  output logic [7:0]    vid_dat_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_dat_i,
  output logic          cpu_ack_o,
  output logic [7:0]    cpu_dat_o,
  input  logic          hst_req_i,
  input  logic          hst_we_i,
  input  logic [AW-1:0] hst_addr_i,
  input  logic [7:0]    hst_dat_i,
  output logic          hst_ack_o,
  output logic [7:0]    hst_dat_o,
  output logic          mem_cs_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_dat_o,
  input  logic [7:0]    mem_dat_i
);

  localparam int unsigned    CW       = 4;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    gnt_q;   // one-hot {hst, cpu, vid}
  logic [2:0]    pick_c;
  logic          fair_q;  // 0: CPU wins a CPU/host tie, 1: host wins
  logic          last_c;

  assign last_c = (cnt_q == '0);

  // Grant selection: video first, then CPU/host tie broken by the fairness bit
  always_comb begin
    pick_c = 3'b000;
    if (vid_req_i) begin
      pick_c = 3'b001;
    end else if (cpu_req_i && hst_req_i) begin
      pick_c = fair_q ? 3'b100 : 3'b010;
    end else if (cpu_req_i) begin
      pick_c = 3'b010;
    end else if (hst_req_i) begin
      pick_c = 3'b100;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pick_c != 3'b000) state_d = S_ACCESS;
      S_ACCESS: if (last_c) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath: latch the winner, run the window, capture read data, pulse ack
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      gnt_q      <= 3'b000;
      fair_q     <= 1'b0;
      vid_ack_o  <= 1'b0;
      cpu_ack_o  <= 1'b0;
      hst_ack_o  <= 1'b0;
      vid_dat_o  <= 8'h00;
      cpu_dat_o  <= 8'h00;
      hst_dat_o  <= 8'h00;
      mem_cs_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_dat_o  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_c != 3'b000) begin
            gnt_q    <= pick_c;
            cnt_q    <= CNT_LOAD;
            mem_cs_o <= 1'b1;
            if (pick_c[0]) begin
              mem_addr_o <= vid_addr_i;
              mem_we_o   <= 1'b0;
            end else if (pick_c[1]) begin
              mem_addr_o <= cpu_addr_i;
              mem_we_o   <= cpu_we_i;
              mem_dat_o  <= cpu_dat_i;
              fair_q     <= 1'b1;
            end else begin
              mem_addr_o <= hst_addr_i;
              mem_we_o   <= hst_we_i;
              mem_dat_o  <= hst_dat_i;
              fair_q     <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          if (last_c) begin
            mem_cs_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            vid_ack_o <= gnt_q[0];
            cpu_ack_o <= gnt_q[1];
            hst_ack_o <= gnt_q[2];
            if (!mem_we_o) begin
              if (gnt_q[0]) vid_dat_o <= mem_dat_i;
              if (gnt_q[1]) cpu_dat_o <= mem_dat_i;
              if (gnt_q[2]) hst_dat_o <= mem_dat_i;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          vid_ack_o <= 1'b0;
          cpu_ack_o <= 1'b0;
          hst_ack_o <= 1'b0;
        end
        default: begin
          mem_cs_o <= 1'b0;
          mem_we_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
